// File: rtl/spi_slave_ram_param.sv
// SPI slave with an on-chip register-file RAM, driven by a small command FSM.
// Frame = 2 command bits + max(ADDR_WIDTH, DATA_WIDTH) payload bits, MSB first.
module spi_slave_ram_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(PW + 4);
  localparam int TW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]         CNT_CAP_END = CW'(PW + 1);
  localparam logic [CW-1:0]         CNT_EXEC    = CW'(PW + 2);
  localparam logic [CW-1:0]         CNT_DONE    = CW'(PW + 3);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A      = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);
  localparam logic [TW-1:0]         TX_FIRST    = TW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0]         TX_ONE      = TW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  // Post-increment with wrap at the last implemented word.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a >= LAST_A) begin
      return '0;
    end else begin
      return a + ONE_A;
    end
  endfunction

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r;
  logic [PW:0]             shift_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r, rd_addr_r;
  logic                    rd_valid_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   tx_r;
  logic [TW-1:0]           tx_left_r;
  logic                    miso_r, frame_err_r;

  logic                    capture_s, exec_s, cmd0_s;
  logic [PW-1:0]           payload_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic                    ld_wr_addr_s, mem_we_s, inc_wr_s;
  logic                    ld_rd_addr_s, rd_load_s, clr_valid_s, err_s;

  assign cmd0_s    = shift_r[PW];
  assign payload_s = shift_r[PW-1:0];
  assign rd_word_s = in_range(rd_addr_r) ? mem_r[rd_addr_r] : '0;
  assign MISO      = miso_r;
  assign frame_err = frame_err_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; the read branch is chosen at E1 from rd_addr_valid.
  always_comb begin
    state_s = state_r;
    if (SS_n) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = CHK_CMD;
        CHK_CMD: begin
          if (MOSI) begin
            state_s = rd_valid_r ? READ_DATA : READ_ADD;
          end else begin
            state_s = WRITE;
          end
        end
        WRITE, READ_ADD, READ_DATA: state_s = state_r;
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM outputs: capture window, execute strobe and per-command actions.
  always_comb begin
    capture_s    = 1'b0;
    exec_s       = 1'b0;
    ld_wr_addr_s = 1'b0;
    mem_we_s     = 1'b0;
    inc_wr_s     = 1'b0;
    ld_rd_addr_s = 1'b0;
    rd_load_s    = 1'b0;
    clr_valid_s  = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      WRITE, READ_ADD, READ_DATA: begin
        capture_s = !SS_n && (cnt_r >= CNT_ONE) && (cnt_r <= CNT_CAP_END);
        exec_s    = !SS_n && (cnt_r == CNT_EXEC);
      end
      default: begin
        capture_s = 1'b0;
        exec_s    = 1'b0;
      end
    endcase
    if (exec_s) begin
      case (state_r)
        WRITE: begin
          if (cmd0_s) begin
            mem_we_s = in_range(wr_addr_r);
            err_s    = !in_range(wr_addr_r);
            inc_wr_s = (AUTO_INC != 0);
          end else begin
            ld_wr_addr_s = 1'b1;
          end
        end
        READ_ADD: begin
          if (cmd0_s) begin
            err_s = 1'b1;
          end else begin
            ld_rd_addr_s = 1'b1;
          end
        end
        READ_DATA: begin
          if (cmd0_s) begin
            rd_load_s   = 1'b1;
            err_s       = !in_range(rd_addr_r);
            clr_valid_s = (AUTO_INC == 0);
          end else begin
            err_s = 1'b1;
          end
        end
        default: err_s = 1'b0;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Edge counter within the frame; saturates once the command has executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (SS_n || state_r == IDLE) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_DONE) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Command bit 0 plus payload shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
    end else if (capture_s) begin
      shift_r <= {shift_r[PW-1:0], MOSI};
    end
  end

  // Address registers and read-address valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r  <= '0;
      rd_addr_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      if (ld_wr_addr_s) begin
        wr_addr_r <= payload_s[ADDR_WIDTH-1:0];
      end else if (inc_wr_s) begin
        wr_addr_r <= next_addr(wr_addr_r);
      end
      if (ld_rd_addr_s) begin
        rd_addr_r <= payload_s[ADDR_WIDTH-1:0];
      end else if (rd_load_s && AUTO_INC != 0) begin
        rd_addr_r <= next_addr(rd_addr_r);
      end
      if (ld_rd_addr_s) begin
        rd_valid_r <= 1'b1;
      end else if (clr_valid_s) begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr_r] <= payload_s[DATA_WIDTH-1:0];
    end
  end

  // Read shift-out: MSB appears right after the load edge, then one bit per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r    <= 1'b0;
      tx_r      <= '0;
      tx_left_r <= '0;
    end else if (rd_load_s) begin
      miso_r    <= rd_word_s[DATA_WIDTH-1];
      tx_r      <= rd_word_s << 1'b1;
      tx_left_r <= TX_FIRST;
    end else if (state_r == READ_DATA && !SS_n && tx_left_r != '0) begin
      miso_r    <= tx_r[DATA_WIDTH-1];
      tx_r      <= tx_r << 1'b1;
      tx_left_r <= tx_left_r - TX_ONE;
    end else begin
      miso_r    <= 1'b0;
      tx_left_r <= '0;
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_s;
    end
  end

endmodule

// File: doc/spi_slave_ram_param.md
Name: spi_slave_ram_param

Overview:
- Parametrised SPI slave with on-chip single-port RAM, controlled by a small command FSM.
- Successor to the fixed 8-bit-address / 8-bit-data slave-plus-RAM interface.
- Adds configurable widths and depth, optional address auto-increment for burst access, and a protocol-error flag.
- Sits at chip top, directly on the SPI pins, clocked by the SPI-domain clock.

Parameters:
ADDR_WIDTH, 8, RAM address width (1..16)
DATA_WIDTH, 8, RAM word width (1..32)
MEM_DEPTH, 256, number of RAM words (<= 2**ADDR_WIDTH)
AUTO_INC, 0, 1 = write/read addresses increment after each data access

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low, sampled on clk
MOSI  input  1  serial data in, MSB first, sampled on clk
MISO  output  1  serial data out, MSB first, registered
frame_err  output  1  one-cycle pulse on protocol error

Behaviour:
- PW = max(ADDR_WIDTH, DATA_WIDTH). Frame = 2 command bits + PW payload bits, MSB first. Payload is right-aligned; unused upper bits are ignored.
- Commands:
  - 00 WR_ADDR: wr_addr <= payload
  - 01 WR_DATA: mem[wr_addr] <= payload
  - 10 RD_ADDR: rd_addr <= payload; rd_addr_valid <= 1
  - 11 RD_DATA: read mem[rd_addr] and shift it out; payload is don't-care
- Reset: FSM = IDLE; bit counter, wr_addr, rd_addr and rd_addr_valid cleared; MISO = 0; frame_err = 0. RAM contents are not reset.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Any state goes to IDLE on the first edge sampling SS_n = 1.
- Frame timing:
  - Edge E0: IDLE samples SS_n = 0 and moves to CHK_CMD; no MOSI capture.
  - E1: captures cmd[1]. Next state is WRITE if cmd[1] = 0; READ_ADD if cmd[1] = 1 and rd_addr_valid = 0; READ_DATA if cmd[1] = 1 and rd_addr_valid = 1.
  - E2..E(PW+2): capture cmd[0] and the payload.
  - E(PW+3): command executes.
- State/command mismatch (cmd 10 in READ_DATA, or cmd 11 in READ_ADD): command discarded; frame_err = 1 for the cycle after E(PW+3).
- RD_DATA shift-out:
  - tx word loaded from RAM at E(PW+3).
  - MISO = tx[DATA_WIDTH-1] after E(PW+3), then one lower bit per edge.
  - LSB is valid after E(PW+2+DATA_WIDTH). MISO = 0 after that.
- MISO = 0 in all states other than READ_DATA shift-out.
- rd_addr_valid after RD_DATA: AUTO_INC = 0 clears it at the end of the frame. AUTO_INC = 1 keeps it set.
- Auto-increment (AUTO_INC = 1):
  - WR_DATA post-increments wr_addr.
  - RD_DATA post-increments rd_addr at load time.
  - Both wrap from MEM_DEPTH-1 to 0.
- Address >= MEM_DEPTH on a WR_DATA/RD_DATA access: write dropped, read returns 0, frame_err pulses.
- Extra bits after frame completion while SS_n stays low are ignored. Exactly one command executes per SS_n low period.
- SS_n high before E(PW+2): frame aborted, nothing executes, no error, bit counter cleared. SS_n high during RD_DATA shift-out: shifting stops, MISO = 0 next cycle; the auto-increment already applied stands.
- rst_n low at any time, including mid-frame: immediate return to reset values; a partial frame has no effect.

Test Plan:
- Defaults: WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> MISO shifts 1010_0101 starting after E11; frame_err stays 0.
- AUTO_INC = 1: WR_ADDR 0xFE, then WR_DATA 0x11, 0x22, 0x33 (three frames) -> mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33 (wrap).
- After reset, send cmd 11 -> FSM enters READ_ADD, command discarded, frame_err pulses one cycle, MISO stays 0.
- WR_ADDR 0x10, then WR_DATA 0x77 with SS_n raised after E6 -> mem[0x10] unchanged, FSM back in IDLE, no frame_err.
- AUTO_INC = 0: RD_ADDR 0x05 followed by two RD_DATA frames -> first returns mem[0x05]; second lands in READ_ADD, flags frame_err, MISO = 0.
- rst_n pulsed low mid-RD_DATA shift-out -> MISO = 0 immediately, FSM = IDLE, rd_addr_valid = 0.
